// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM write-side blitter.
package vram_pkg;

    localparam int FB_W_DEF    = 160;
    localparam int FB_H_DEF    = 120;
    localparam int X_W_DEF     = 8;
    localparam int Y_W_DEF     = 7;
    localparam int VRAM_ADDR_W = 15;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       a;
    } rgba13_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} blit_state_t;

    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic [X_W_DEF-1:0] w;
        logic [Y_W_DEF-1:0] h;
        rgba13_t            color;
    } rect_cmd_t;

    // Constant multiply as shift-and-add; with a constant k this reduces to a few adders.
    function automatic logic [31:0] mul_const(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) r = r + (a << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_blitter_raster_walker.sv
// Raster walker: column/row counters, running row base address and clip test.
module raster_walker
    import vram_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [Y_W-1:0]    load_y,
    input  logic              step,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic [ADDR_W-1:0] addr,
    output logic              in_fb,
    output logic              last
);

    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;
    logic [ADDR_W-1:0] row_base;
    logic [X_W:0]      px;
    logic [Y_W:0]      py;
    logic              row_end;

    // One extra bit so x+cx past 2^X_W stays out of range instead of wrapping.
    assign px      = {1'b0, x} + {1'b0, cx};
    assign py      = {1'b0, y} + {1'b0, cy};
    assign in_fb   = (px < (X_W+1)'(FB_W)) && (py < (Y_W+1)'(FB_H));
    assign addr    = row_base + ADDR_W'(px);
    assign row_end = (cx == w - X_W'(1));
    assign last    = row_end && (cy == h - Y_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cx       <= '0;
            cy       <= '0;
            row_base <= '0;
        end else if (load) begin
            cx       <= '0;
            cy       <= '0;
            row_base <= ADDR_W'(mul_const(32'(load_y), 32'(FB_W)));
        end else if (step) begin
            if (row_end) begin
                cx       <= '0;
                cy       <= cy + Y_W'(1);
                row_base <= row_base + ADDR_W'(FB_W);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/vram_blitter.sv
// Rectangle-fill blitter: accepts fill commands and streams clipped VRAM writes in raster order.
module vram_blitter
    import vram_pkg::*;
#(
    parameter int FB_W        = FB_W_DEF,
    parameter int FB_H        = FB_H_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int GATE_VBLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [X_W-1:0]    cmd_w,
    input  logic [Y_W-1:0]    cmd_h,
    input  logic [12:0]       cmd_color,
    input  logic              vblank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [12:0]       wr_data,
    output logic              busy,
    output logic              done
);

    blit_state_t       state, state_nx;
    rect_cmd_t         cmd;
    logic              accept, zero, step, last, last_q, in_fb;
    logic [ADDR_W-1:0] pix_addr;

    assign accept    = (state == IDLE) && cmd_valid;
    assign zero      = (cmd_w == '0) || (cmd_h == '0);
    // last_q marks the cycle the final write is on the bus; no further steps after it.
    assign step      = (state == RUN) && !last_q && ((GATE_VBLANK == 0) || vblank);
    assign cmd_ready = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    raster_walker #(
        .FB_W(FB_W), .FB_H(FB_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .load_y (cmd_y),
        .step   (step),
        .x      (X_W'(cmd.x)),
        .y      (Y_W'(cmd.y)),
        .w      (X_W'(cmd.w)),
        .h      (Y_W'(cmd.h)),
        .addr   (pix_addr),
        .in_fb  (in_fb),
        .last   (last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = zero ? DONE : RUN;
            RUN:     if (last_q) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_en  <= step && in_fb;
            last_q <= step && last;
            if (accept) begin
                cmd.x     <= X_W_DEF'(cmd_x);
                cmd.y     <= Y_W_DEF'(cmd_y);
                cmd.w     <= X_W_DEF'(cmd_w);
                cmd.h     <= Y_W_DEF'(cmd_h);
                cmd.color <= rgba13_t'(cmd_color);
            end
            // Address/data only move on real writes so they hold through stalls and clips.
            if (step && in_fb) begin
                wr_addr <= pix_addr;
                wr_data <= cmd.color;
            end
        end
    end

endmodule

// File: tb/tb_vram_blitter.sv
// Scoreboard bench for vram_blitter: directed fills, clipping, vblank gating, back-to-back and reset abort.
module tb_vram_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0;
    logic [6:0]  cmd_y = '0;
    logic [7:0]  cmd_w = '0;
    logic [6:0]  cmd_h = '0;
    logic [12:0] cmd_color = '0;
    logic        vblank = 1'b1;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [12:0] wr_data;
    logic        busy;
    logic        done;

    vram_blitter #(.GATE_VBLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .vblank(vblank), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    // Monitor: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en === 1'b1) begin
                if (exp_wr.size() == 0) flag("unexpected_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) flag("unexpected_done");
                else check("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    // Raises cmd_valid and returns the cycle in which the handshake completed.
    task automatic send(input int x, input int y, input int w, input int h, input int col, output int acc);
        cmd_valid = 1'b1;
        cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 13'(col);
        acc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) flag("accept_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x = 8'($urandom); cmd_y = 7'($urandom); cmd_w = 8'($urandom);
        cmd_h = 7'($urandom); cmd_color = 13'($urandom);
    endtask

    task automatic drain();
        int ok;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            if (exp_wr.size() == 0 && exp_done.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        if (ok == 0) flag("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int c);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cyc == c) return;
        end
        flag("wait_timeout");
    endtask

    initial begin
        int a, b;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 2x2 fill at (10,5): rows 5 and 6 -> 810,811,970,971
        send(10, 5, 2, 2, 'h1FFF, a);
        exp_wr.push_back('{a+2, 810, 'h1FFF});
        exp_wr.push_back('{a+3, 811, 'h1FFF});
        exp_wr.push_back('{a+4, 970, 'h1FFF});
        exp_wr.push_back('{a+5, 971, 'h1FFF});
        exp_done.push_back(a+6);
        wait_neg(a+6);
        check("t1_ready_in_done", int'(cmd_ready), 0);
        check("t1_busy_in_done", int'(busy), 1);
        @(negedge clk);
        check("t1_ready_after", int'(cmd_ready), 1);
        check("t1_busy_after", int'(busy), 0);
        drain();

        // zero width: straight to DONE, no writes
        send(3, 3, 0, 5, 'h0123, a);
        exp_done.push_back(a+1);
        @(negedge clk);
        check("t2_busy", int'(busy), 1);
        check("t2_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("t2_busy_after", int'(busy), 0);
        drain();

        // bottom-right corner clip: only (159,119) lands
        send(159, 119, 2, 2, 'h0A5A, a);
        exp_wr.push_back('{a+2, 19199, 'h0A5A});
        exp_done.push_back(a+6);
        drain();

        // x+w crossing 256 must not wrap into the framebuffer
        send(250, 0, 8, 1, 'h1111, a);
        exp_done.push_back(a+10);
        drain();

        // vblank low for 10 cycles after acceptance
        vblank = 1'b0;
        send(0, 0, 3, 1, 'h1234, a);
        exp_wr.push_back('{a+12, 0, 'h1234});
        exp_wr.push_back('{a+13, 1, 'h1234});
        exp_wr.push_back('{a+14, 2, 'h1234});
        exp_done.push_back(a+15);
        repeat (10) @(posedge clk);
        #1 vblank = 1'b1;
        drain();

        // vblank dropped mid-row freezes the address
        send(20, 3, 3, 1, 'h0F0F, a);
        exp_wr.push_back('{a+2, 500, 'h0F0F});
        exp_wr.push_back('{a+5, 501, 'h0F0F});
        exp_wr.push_back('{a+6, 502, 'h0F0F});
        exp_done.push_back(a+7);
        @(posedge clk); #1 vblank = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_hold_wr_en", int'(wr_en), 0);
        check("t5_hold_addr", int'(wr_addr), 500);
        @(posedge clk); #1 vblank = 1'b1;
        @(negedge clk);
        check("t5_hold_addr2", int'(wr_addr), 500);
        drain();

        // back-to-back: B held valid during A, accepted the cycle after A's done
        send(0, 0, 2, 1, 'h0111, a);
        exp_wr.push_back('{a+2, 0, 'h0111});
        exp_wr.push_back('{a+3, 1, 'h0111});
        exp_done.push_back(a+4);
        send(1, 1, 1, 1, 'h0222, b);
        check("t6_accept_gap", b - a, 5);
        exp_wr.push_back('{b+2, 161, 'h0222});
        exp_done.push_back(b+3);
        drain();

        // reset during the 2nd pixel of a 4x4 fill aborts it
        send(0, 10, 4, 4, 'h1ABC, a);
        exp_wr.push_back('{a+2, 1600, 'h1ABC});
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t7_wr_en", int'(wr_en), 0);
        check("t7_wr_addr", int'(wr_addr), 0);
        check("t7_wr_data", int'(wr_data), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_done", int'(done), 0);
        check("t7_ready", int'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;

        // normal command after the abort
        send(5, 5, 1, 2, 'h0055, a);
        exp_wr.push_back('{a+2, 805, 'h0055});
        exp_wr.push_back('{a+3, 965, 'h0055});
        exp_done.push_back(a+4);
        drain();

        check("left_writes", exp_wr.size(), 0);
        check("left_dones", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
